dmem_port: RTL

Data-memory responder for the single-issue MIPS datapath. It consumes the load/store controls produced by the main controller (MemRead, MemWrite, opcode) with the ALU-computed address and store data. It performs byte, halfword and word accesses against an internal word-organised SRAM with configurable latency, and returns sign- or zero-extended load data. It stalls the pipeline while an access is outstanding and flags misaligned, out-of-range or illegal requests.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/dmem_port_if.sv | 23 ++
 rtl/dmem_sram.sv | 30 +++
 rtl/dmem_port.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, access sizes, data-memory FSM states
// and the load/store opcode decoder used by the data-memory port.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  typedef struct packed {
    logic  legal;
    logic  store;
    logic  sext;
    size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d.legal = 1'b1;
    d.store = 1'b0;
    d.sext  = 1'b0;
    d.size  = WORD;
    case (op)
      OP_LB:   begin d.sext = 1'b1; d.size = BYTE; end
      OP_LBU:  d.size = BYTE;
      OP_LH:   begin d.sext = 1'b1; d.size = HALF; end
      OP_LHU:  d.size = HALF;
      OP_LW:   d.size = WORD;
      OP_SB:   begin d.store = 1'b1; d.size = BYTE; end
      OP_SH:   begin d.store = 1'b1; d.size = HALF; end
      OP_SW:   d.store = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Requester-to-data-memory bus: load/store controls in, extended data and
// handshake status out.
interface dmem_port_if;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  modport master (
    output mem_read, mem_write, opcode, addr, wdata,
    input  rdata, done, err, stall
  );

  modport slave (
    input  mem_read, mem_write, opcode, addr, wdata,
    output rdata, done, err, stall
  );
endinterface

// File: rtl/dmem_sram.sv
// Single-port word-organised SRAM with per-byte write enables and a
// registered read port (data valid the cycle after the read).
module dmem_sram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata_q
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_port.sv
// Data-memory responder: decodes load/store requests, sequences the SRAM
// access through IDLE/WAIT/RESP and returns big-endian lane-extracted data.
module dmem_port
  import mips_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req, req_bad, misalign, range_bad, dir_bad, commit;
  mem_op_t     in_dec, cur_dec;
  logic [3:0]  sram_be;
  logic [31:0] sram_wd, sram_rd, shifted, ld_data;
  logic        unused_ok;

  assign req     = bus.mem_read | bus.mem_write;
  assign in_dec  = decode_op(bus.opcode);
  assign cur_dec = decode_op(op_q);

  // A load opcode must arrive with mem_read only, a store opcode with mem_write only.
  assign misalign  = ((in_dec.size == HALF) && bus.addr[0]) ||
                     ((in_dec.size == WORD) && (bus.addr[1:0] != 2'b00));
  assign range_bad = {2'b00, bus.addr[31:2]} >= 32'(DEPTH);
  assign dir_bad   = (bus.mem_read & bus.mem_write) || (in_dec.store != bus.mem_write);
  assign req_bad   = !in_dec.legal || misalign || range_bad || dir_bad;

  assign commit = (state_q == WAIT) && (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = bus.opcode;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Big-endian lanes: byte offset 0 is be[3] / bits 31:24.
  always_comb begin
    sram_be = 4'b1111;
    sram_wd = wdata_q;
    case (cur_dec.size)
      BYTE: begin
        sram_be = 4'b1000 >> addr_q[1:0];
        sram_wd = {4{wdata_q[7:0]}};
      end
      HALF: begin
        sram_be = addr_q[1] ? 4'b0011 : 4'b1100;
        sram_wd = {2{wdata_q[15:0]}};
      end
      default: sram_be = 4'b1111;
    endcase
  end

  // Reset on the commit edge suppresses the access, so an aborted store never lands.
  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk     (clk),
    .en      (commit & reset_n),
    .we      (cur_dec.store),
    .be      (sram_be),
    .idx     (addr_q[AW+1:2]),
    .wdata   (sram_wd),
    .rdata_q (sram_rd)
  );

  assign shifted = sram_rd << {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = sram_rd;
    case (cur_dec.size)
      BYTE:    ld_data = cur_dec.sext ? {{24{shifted[31]}}, shifted[31:24]}
                                      : {24'd0, shifted[31:24]};
      HALF:    ld_data = cur_dec.sext ? {{16{shifted[31]}}, shifted[31:16]}
                                      : {16'd0, shifted[31:16]};
      default: ld_data = sram_rd;
    endcase
  end

  assign bus.done  = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && err_q;
  assign bus.rdata = ((state_q == RESP) && !err_q && !cur_dec.store) ? ld_data : 32'd0;
  assign bus.stall = ((state_q == IDLE) && req) || (state_q == WAIT);

  assign unused_ok = ^{addr_q[31:AW+2], cur_dec.legal, in_dec.sext};

endmodule
